// File: rtl/adc_rx_align.sv
// Interleaved-DDR ADC link alignment: trains each link on a per-channel
// test pattern, resolves slot ordering, deinterleaves and formats samples.
module adc_rx_align #(
    parameter int                    DATA_WIDTH = 14,
    parameter int                    NUM_LINKS  = 1,
    parameter logic [DATA_WIDTH-1:0] PAT_A      = 14'h2AAA,
    parameter logic [DATA_WIDTH-1:0] PAT_B      = 14'h1555,
    parameter int                    LOCK_COUNT = 64,
    parameter int                    TIMEOUT    = 4096
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_LINKS*DATA_WIDTH-1:0]   d_rise,
    input  logic [NUM_LINKS*DATA_WIDTH-1:0]   d_fall,
    input  logic [NUM_LINKS-1:0]              or_rise,
    input  logic [NUM_LINKS-1:0]              or_fall,
    input  logic                              train_start,
    input  logic                              fmt_twos,
    input  logic                              or_clr,
    output logic [2*NUM_LINKS*DATA_WIDTH-1:0] ch_data,
    output logic                              ch_valid,
    output logic [2*NUM_LINKS-1:0]            or_sticky,
    output logic [NUM_LINKS-1:0]              locked,
    output logic [NUM_LINKS-1:0]              swapped,
    output logic                              train_busy,
    output logic                              train_fail
);

    localparam int DW = DATA_WIDTH;
    localparam int NL = NUM_LINKS;
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_COUNT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] MSB_MASK = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        TRAIN,
        RUN,
        FAIL
    } state_t;

    state_t state, state_nxt;

    logic [NL*DW-1:0]   s1_rise, s1_fall;
    logic [NL-1:0]      s1_or_rise, s1_or_fall;
    logic [NL-1:0]      hit_norm, hit_swap;
    logic [CW-1:0]      match_cnt [NL];
    logic [TW-1:0]      tmo_cnt;
    logic               all_locked;
    logic [DW-1:0]      fmt_mask;
    logic [2*NL*DW-1:0] ch_nxt;
    logic [2*NL-1:0]    or_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rise    <= '0;
            s1_fall    <= '0;
            s1_or_rise <= '0;
            s1_or_fall <= '0;
        end else begin
            s1_rise    <= d_rise;
            s1_fall    <= d_fall;
            s1_or_rise <= or_rise;
            s1_or_fall <= or_fall;
        end
    end

    always_comb begin
        hit_norm = '0;
        hit_swap = '0;
        for (int k = 0; k < NL; k++) begin
            hit_norm[k] = (s1_rise[k*DW +: DW] == PAT_A) &&
                          (s1_fall[k*DW +: DW] == PAT_B);
            hit_swap[k] = (s1_rise[k*DW +: DW] == PAT_B) &&
                          (s1_fall[k*DW +: DW] == PAT_A);
        end
    end

    assign all_locked = &locked;

    // Locking on the same cycle as the timeout still enters RUN.
    always_comb begin
        state_nxt = state;
        if (train_start) begin
            state_nxt = TRAIN;
        end else begin
            case (state)
                TRAIN: begin
                    if (all_locked)
                        state_nxt = RUN;
                    else if (tmo_cnt == TMO_LAST)
                        state_nxt = FAIL;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || train_start)
            tmo_cnt <= '0;
        else if (state == TRAIN && tmo_cnt != TMO_LAST)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // A word breaking a run is re-evaluated as the start of a new run.
    always_ff @(posedge clk) begin
        if (rst || train_start) begin
            for (int k = 0; k < NL; k++)
                match_cnt[k] <= '0;
            locked  <= '0;
            swapped <= '0;
        end else if (state == TRAIN) begin
            for (int k = 0; k < NL; k++) begin
                if (!locked[k]) begin
                    if (match_cnt[k] != '0 &&
                        (swapped[k] ? hit_swap[k] : hit_norm[k])) begin
                        if (match_cnt[k] != CNT_MAX)
                            match_cnt[k] <= match_cnt[k] + 1'b1;
                        if (match_cnt[k] == CNT_MAX - 1'b1)
                            locked[k] <= 1'b1;
                    end else if (hit_norm[k] || hit_swap[k]) begin
                        match_cnt[k] <= CW'(1);
                        swapped[k]   <= hit_swap[k];
                        if (LOCK_COUNT == 1)
                            locked[k] <= 1'b1;
                    end else begin
                        match_cnt[k] <= '0;
                    end
                end
            end
        end
    end

    assign fmt_mask = fmt_twos ? MSB_MASK : '0;

    always_comb begin
        ch_nxt = '0;
        or_hit = '0;
        for (int k = 0; k < NL; k++) begin
            ch_nxt[2*k*DW +: DW] = fmt_mask ^
                (swapped[k] ? s1_fall[k*DW +: DW] : s1_rise[k*DW +: DW]);
            ch_nxt[(2*k+1)*DW +: DW] = fmt_mask ^
                (swapped[k] ? s1_rise[k*DW +: DW] : s1_fall[k*DW +: DW]);
            or_hit[2*k]   = swapped[k] ? s1_or_fall[k] : s1_or_rise[k];
            or_hit[2*k+1] = swapped[k] ? s1_or_rise[k] : s1_or_fall[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_data   <= '0;
            ch_valid  <= 1'b0;
            or_sticky <= '0;
        end else begin
            ch_data   <= ch_nxt;
            ch_valid  <= (state == RUN);
            or_sticky <= (or_clr ? '0 : or_sticky) | or_hit;
        end
    end

    assign train_busy = (state == TRAIN);
    assign train_fail = (state == FAIL);

endmodule
